// File: rtl/mul64_seq_ctrl.sv
// 64x64 unsigned multiply sequenced over one shared 32x32 multiplier.
// Four passes accumulate the partial products into a 128-bit result.
module mul64_seq_ctrl #(
  parameter int MUL_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic         busy,
  output logic         done,
  output logic [127:0] result,
  output logic [31:0]  mul_a,
  output logic [31:0]  mul_b,
  input  logic [63:0]  mul_p
);

  localparam int CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_LAT);

  typedef enum logic [2:0] {
    IDLE,
    P0,
    P1,
    P2,
    P3,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    a_r_q, a_r_d;
  logic [63:0]    b_r_q, b_r_d;
  logic [127:0]   acc_q, acc_d;
  logic [127:0]   result_q, result_d;
  logic [31:0]    mul_a_q, mul_a_d;
  logic [31:0]    mul_b_q, mul_b_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [127:0]   pp;
  logic           last;

  assign pp   = {64'b0, mul_p};
  assign last = (cnt_q == LAST);

  // Next-state: accept, per-pass operand select, wait count, accumulate
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_r_d    = a_r_q;
    b_r_d    = b_r_q;
    acc_d    = acc_q;
    result_d = result_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_r_d   = a;
          b_r_d   = b;
          acc_d   = '0;
          cnt_d   = '0;
          mul_a_d = a[31:0];
          mul_b_d = b[31:0];
          state_d = P0;
        end else begin
          state_d = IDLE;
        end
      end
      P0: begin
        if (last) begin
          acc_d   = acc_q + pp;
          cnt_d   = '0;
          mul_a_d = a_r_q[31:0];
          mul_b_d = b_r_q[63:32];
          state_d = P1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      P1: begin
        if (last) begin
          acc_d   = acc_q + (pp << 32);
          cnt_d   = '0;
          mul_a_d = a_r_q[63:32];
          mul_b_d = b_r_q[31:0];
          state_d = P2;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      P2: begin
        if (last) begin
          acc_d   = acc_q + (pp << 32);
          cnt_d   = '0;
          mul_a_d = a_r_q[63:32];
          mul_b_d = b_r_q[63:32];
          state_d = P3;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      P3: begin
        if (last) begin
          result_d = acc_q + (pp << 64);
          cnt_d    = '0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == P0) || (state_d == P1) ||
             (state_d == P2) || (state_d == P3);
    done_d = (state_d == DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_r_q    <= '0;
      b_r_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_r_q    <= a_r_d;
      b_r_q    <= b_r_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;

endmodule

// File: tb/tb_mul64_seq_ctrl.sv
// Bench for mul64_seq_ctrl: scoreboard queues filled by the drivers,
// drained by done-triggered monitors (MUL_LAT=0 and MUL_LAT=2 instances).
module tb_mul64_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         s0, busy0, done0;
  logic [63:0]  a0, b0, mp0;
  logic [127:0] r0;
  logic [31:0]  ma0, mb0;

  logic         s2, busy2, done2;
  logic [63:0]  a2, b2, mp2, pipe1, pipe2;
  logic [127:0] r2;
  logic [31:0]  ma2, mb2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [127:0] r;
    time          t;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  exp_t e0, e2;

  always #5 clk = ~clk;

  mul64_seq_ctrl #(.MUL_LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(s0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .result(r0),
    .mul_a(ma0), .mul_b(mb0), .mul_p(mp0)
  );

  mul64_seq_ctrl #(.MUL_LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(s2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(r2),
    .mul_a(ma2), .mul_b(mb2), .mul_p(mp2)
  );

  assign mp0 = {32'b0, ma0} * {32'b0, mb0};

  always @(posedge clk) begin
    pipe1 <= {32'b0, ma2} * {32'b0, mb2};
    pipe2 <= pipe1;
  end
  assign mp2 = pipe2;

  function automatic logic [127:0] ref_mul(input logic [63:0] x,
                                           input logic [63:0] y);
    return {64'b0, x} * {64'b0, y};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done0) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done0_unexpected got=1 want=0 t=%0t", $time);
      end else begin
        e0 = q0.pop_front();
        chk("result0", r0, e0.r);
        chk("latency0", 128'($time - e0.t), 128'(45));
        chk("busy_at_done0", {127'b0, busy0}, 128'(0));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done2) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done2_unexpected got=1 want=0 t=%0t", $time);
      end else begin
        e2 = q2.pop_front();
        chk("result2", r2, e2.r);
        chk("latency2", 128'($time - e2.t), 128'(125));
      end
    end
  end

  task automatic issue0(input logic [63:0] x, input logic [63:0] y,
                        input logic [127:0] e);
    int g;
    g = 0;
    @(negedge clk);
    while (busy0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      total++;
      bad++;
      $display("FAIL issue0_timeout got=busy want=idle t=%0t", $time);
    end
    s0 = 1'b1;
    a0 = x;
    b0 = y;
    @(posedge clk);
    q0.push_back('{e, $time});
  endtask

  task automatic idle0();
    @(negedge clk);
    s0 = 1'b0;
    a0 = {$urandom, $urandom};
    b0 = {$urandom, $urandom};
  endtask

  initial begin
    int n, g;
    logic [63:0] x, y;
    logic [31:0] ea[4], eb[4];
    s0 = 0; a0 = 0; b0 = 0;
    s2 = 0; a2 = 0; b2 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {127'b0, busy0}, 128'(0));
    chk("rst_done", {127'b0, done0}, 128'(0));
    chk("rst_result", r0, 128'(0));
    chk("rst_mul_a", {96'b0, ma0}, 128'(0));
    chk("rst_mul_b", {96'b0, mb0}, 128'(0));

    issue0(64'd3, 64'd5, 128'hF);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      s0 = 1'b0;
      if (busy0) n++;
    end
    chk("busy_cycles", 128'(n), 128'(4));

    issue0(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
           128'hFFFFFFFFFFFFFFFE0000000000000001);
    issue0(64'h0000000100000000, 64'h0000000100000000,
           128'h00000000000000010000000000000000);
    issue0(64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF,
           128'h00000000FFFFFFFE0000000100000000);
    issue0(64'h00000000FFFFFFFF, 64'hFFFFFFFF00000000,
           128'h00000000FFFFFFFE0000000100000000);
    idle0();
    repeat (6) @(negedge clk);

    issue0(64'd2, 64'd3, 128'd6);
    issue0(64'h0000000100000000, 64'd7, 128'h700000000);
    idle0();
    repeat (6) @(negedge clk);

    issue0(64'd7, 64'd9, 128'd63);
    @(negedge clk);
    s0 = 1'b1;
    a0 = 64'hAAAA;
    b0 = 64'hBBBB;
    @(negedge clk);
    s0 = 1'b0;
    repeat (6) @(negedge clk);

    issue0(64'hDEADBEEF00000001, 64'h1234,
           ref_mul(64'hDEADBEEF00000001, 64'h1234));
    idle0();
    #18;
    rst = 1'b1;
    #1;
    q0.delete();
    chk("abort_busy", {127'b0, busy0}, 128'(0));
    chk("abort_done", {127'b0, done0}, 128'(0));
    chk("abort_result", r0, 128'(0));
    chk("abort_mul_a", {96'b0, ma0}, 128'(0));
    chk("abort_mul_b", {96'b0, mb0}, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_result_hold", r0, 128'(0));
    issue0(64'd11, 64'd13, 128'd143);
    idle0();
    repeat (6) @(negedge clk);

    x = 64'h123456789ABCDEF0;
    y = 64'h0FEDCBA987654321;
    ea = '{x[31:0], x[31:0], x[63:32], x[63:32]};
    eb = '{y[31:0], y[63:32], y[31:0], y[63:32]};
    @(negedge clk);
    s2 = 1'b1;
    a2 = x;
    b2 = y;
    @(posedge clk);
    q2.push_back('{ref_mul(x, y), $time});
    @(negedge clk);
    s2 = 1'b0;
    a2 = 64'h5555;
    b2 = 64'h6666;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("mul_a2_%0d", i), {96'b0, ma2}, {96'b0, ea[i/3]});
      chk($sformatf("mul_b2_%0d", i), {96'b0, mb2}, {96'b0, eb[i/3]});
    end
    repeat (4) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if (i % 5 == 0) x = 64'hFFFFFFFFFFFFFFFF;
      issue0(x, y, ref_mul(x, y));
      n = $urandom_range(0, 3);
      if (n != 0) begin
        idle0();
        repeat (n) @(negedge clk);
      end
    end
    idle0();

    g = 0;
    while ((q0.size() != 0 || q2.size() != 0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (q0.size() != 0 || q2.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d want=0", q0.size() + q2.size());
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
